cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Instruction fetch/decode/sequencing FSM for the Tetris CPU.
- Sits directly upstream of the datapath:
  - fetches 16-bit instructions from instruction memory;
  - drives the datapath `opcode`/`addr1`/`addr2`/`wr`;
  - latches the returned `psr` for conditional branches;
  - maintains the PC.
- One instruction in flight; no pipelining.

Parameters:
- PC_W, 16, program counter / instruction address width (word addressed).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, held until accepted.
- imem_addr  output  PC_W  fetch address (= pc).
- imem_rdata  input  16  instruction word, valid when imem_valid.
- imem_valid  input  1  memory response; may arrive the same cycle as req or any later cycle.
- opcode  output  4  datapath operation (0..7).
- addr1  output  16  datapath operand/register select 1.
- addr2  output  16  datapath operand/register select 2.
- wr  output  1  datapath register write enable, one-cycle pulse.
- psr  input  5  datapath flags: bit4 Z, bit3 C, bit2 F (overflow), bit1 L, bit0 N.
- flags  output  5  latched PSR.
- pc  output  PC_W  current program counter.
- halted  output  1  high while in HALT state.

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0 and after release:
  - state=FETCH, pc=RESET_PC;
  - imem_req=0 (combinational from state/reset, so it drops immediately mid-fetch);
  - opcode=0, addr1=0, addr2=0, wr=0, flags=0, halted=0, ir=0.
- Instruction format:
  - [15:12] op, [11:8] ra, [7:4] rb, [7:0] imm8/disp8, [3:0] reserved.
- States: FETCH, DECODE, EXECUTE, HALT (2-bit encoding).
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid=1: ir<=imem_rdata, go to DECODE.
  - Otherwise stay; each stall cycle adds exactly one cycle.
- DECODE (1 cycle): register outputs from ir.
  - op 0..6: opcode=op, addr1={12'b0,ra}, addr2={12'b0,rb}.
  - op 7 (LUI): opcode=7, addr1={12'b0,ra}, addr2={8'b0,imm8}.
  - op 8..F: opcode, addr1 and addr2 keep their previous values.
  - Go to EXECUTE.
- EXECUTE (1 cycle):
  - op 0,1,3,4,5,6,7: wr=1 this cycle only; flags<=psr at cycle end.
  - op 2 (CMP): wr=0; flags<=psr.
  - op 8 BEQ: branch if flags[4]=1.
  - op 9 BNE: branch if flags[4]=0.
  - op A JMP: always branch.
  - op F: go to HALT, pc unchanged.
  - op B..E: NOP.
  - PC update:
    - taken branch: pc<=pc+1+sext(disp8);
    - otherwise: pc<=pc+1.
    - Arithmetic is modulo 2^PC_W, so wrap-around at the top of memory is legal.
  - Next state: FETCH, except HALT for op F.
- Branches test flags as they stood before this instruction; branch/NOP/HALT never modify flags.
- Latency: ALU instruction = 3 cycles with zero wait states (FETCH, DECODE, EXECUTE); +1 cycle per memory stall cycle.
- opcode/addr1/addr2 hold their values from DECODE until the next DECODE. wr is 0 in every state except the EXECUTE cases above.
- HALT:
  - imem_req=0, wr=0, halted=1.
  - Exit only via reset.
- imem_valid outside FETCH is ignored.
- Reset asserted in EXECUTE aborts the instruction: wr drops immediately and neither pc nor flags update.

Optional Feature:
- CPU_CTRL_SINGLE_STEP_EN
  - Defined:
    - adds input port step (1 bit);
    - FETCH does not assert imem_req until a cycle with step=1 has been seen since the last EXECUTE (step captured in a sticky bit, cleared on entering DECODE);
    - allows per-instruction debugging from a board button.
  - Undefined:
    - no step port;
    - FETCH requests immediately.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_ADD=0 … OP_LUI=7, OP_BEQ=8, OP_BNE=9, OP_JMP=A, OP_HALT=F);
  - state encoding;
  - PSR bit indices (PSR_Z=4, PSR_C=3, PSR_F=2, PSR_L=1, PSR_N=0).
- One sub-module, pc_unit:
  - holds the PC register;
  - increment/branch-target adder with disp8 sign extension;
  - load enable.
- The FSM and decode stay in cpu_controller.

Test Plan:
- Reset release, imem_valid tied 1, rdata=0x0120 (ADD r1,r2) → imem_addr=0 in cycle 0; DECODE opcode=0, addr1=0x0001, addr2=0x0002; wr=1 only in cycle 2; pc=1 at cycle 3.
- CMP r1,r1 (0x2110) with psr=5'b10000, then BEQ +4 (0x8004) at pc=1 → flags=10000, wr stays 0 throughout CMP; pc becomes 6 after BEQ.
- Same sequence with psr=5'b00000, then BNE −2 (0x90FE) at pc=1 → branch taken, pc=0. Then BEQ at pc=0 → not taken, pc=1.
- LUI r3,0xAB (0x73AB) with imem_valid delayed 3 cycles → imem_req held 4 cycles with constant imem_addr; addr2=0x00AB; total 6 cycles.
- HALT (0xF000) → halted=1, imem_req=0 for 20 cycles, pc frozen. reset_n pulse → pc=0, fetch resumes.
- reset_n asserted mid-EXECUTE of ADD → wr falls in the same cycle (asynchronous); flags and pc remain at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, state and PSR definitions for the Tetris CPU controller.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_LUI  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int PSR_Z = 4;
    localparam int PSR_C = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_N = 0;

    // Datapath ops that write a register; CMP only updates flags.
    function automatic logic op_writes_reg(input logic [3:0] op);
        return (op <= OP_LUI) && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/cpu_controller_pc_unit.sv
// Program counter: pc+1 or pc+1+sext(disp8) when i_ld, modulo 2^PC_W.
module pc_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_ld,
    input  logic            i_taken,
    input  logic [7:0]      i_disp8,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_disp;
    logic [PC_W-1:0] w_pc_nxt;

    assign w_disp   = i_taken ? {{(PC_W-8){i_disp8[7]}}, i_disp8} : '0;
    assign w_pc_nxt = r_pc + PC_W'(1) + w_disp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (i_ld) begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer: 3 cycles per instruction plus one per imem stall cycle.
// Fetch holds imem_req until imem_valid; CPU_CTRL_SINGLE_STEP_EN gates each fetch on a step press.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [3:0]      opcode,
    output logic [15:0]     addr1,
    output logic [15:0]     addr2,
    output logic            wr,
    input  logic [4:0]      psr,
    output logic [4:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_ir;
    logic [3:0]  r_opcode;
    logic [15:0] r_addr1;
    logic [15:0] r_addr2;
    logic [4:0]  r_flags;
    logic        w_req_en;
    logic        w_req;
    logic        w_accept;
    logic        w_wr;
    logic        w_pc_ld;
    logic        w_taken;
    logic        w_flags_ld;
    logic [3:0]  w_op;

    assign w_op = r_ir[15:12];

`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic r_step_seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step_seen <= 1'b0;
        end else if (r_state == ST_FETCH) begin
            if (w_accept) begin
                r_step_seen <= 1'b0;
            end else if (step) begin
                r_step_seen <= 1'b1;
            end
        end
    end

    assign w_req_en = r_step_seen | step;
`else
    assign w_req_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_accept    = 1'b0;
        w_wr        = 1'b0;
        w_pc_ld     = 1'b0;
        w_taken     = 1'b0;
        w_flags_ld  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_req    = w_req_en;
                w_accept = w_req_en & imem_valid;
                if (w_accept) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_state_nxt = ST_FETCH;
                w_pc_ld     = 1'b1;
                w_wr        = op_writes_reg(w_op);
                w_flags_ld  = (w_op <= OP_LUI);
                case (w_op)
                    OP_BEQ:  w_taken = r_flags[PSR_Z];
                    OP_BNE:  w_taken = ~r_flags[PSR_Z];
                    OP_JMP:  w_taken = 1'b1;
                    OP_HALT: begin
                        w_state_nxt = ST_HALT;
                        w_pc_ld     = 1'b0;
                    end
                    default: w_taken = 1'b0;
                endcase
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir     <= '0;
            r_opcode <= '0;
            r_addr1  <= '0;
            r_addr2  <= '0;
            r_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_ir <= imem_rdata;
            end
            // Branch/NOP/HALT leave the datapath select lines untouched.
            if (r_state == ST_DECODE && w_op <= OP_LUI) begin
                r_opcode <= w_op;
                r_addr1  <= {12'b0, r_ir[11:8]};
                r_addr2  <= (w_op == OP_LUI) ? {8'b0, r_ir[7:0]} : {12'b0, r_ir[7:4]};
            end
            if (w_flags_ld) begin
                r_flags <= psr;
            end
        end
    end

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk     (clk),
        .reset_n (reset_n),
        .i_ld    (w_pc_ld),
        .i_taken (w_taken),
        .i_disp8 (r_ir[7:0]),
        .o_pc    (pc)
    );

    assign imem_req  = w_req & reset_n;
    assign imem_addr = pc;
    assign wr        = w_wr & reset_n;
    assign opcode    = r_opcode;
    assign addr1     = r_addr1;
    assign addr2     = r_addr2;
    assign flags     = r_flags;
    assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller: instruction table plus stall, halt and reset sequences.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [3:0]  opcode;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic        wr;
    logic [4:0]  psr;
    logic [4:0]  flags;
    logic [15:0] pc;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_controller #(.PC_W(16), .RESET_PC(16'h0000)) dut (
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .step       (1'b1),
`endif
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .opcode     (opcode),
        .addr1      (addr1),
        .addr2      (addr2),
        .wr         (wr),
        .psr        (psr),
        .flags      (flags),
        .pc         (pc),
        .halted     (halted)
    );

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  psr;
        logic [3:0]  op;
        logic [15:0] a1;
        logic [15:0] a2;
        logic        wr;
        logic [4:0]  flags;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [15:0] instr, input logic [4:0] p, input logic [3:0] op,
                                input logic [15:0] a1, input logic [15:0] a2, input logic w,
                                input logic [4:0] f, input logic [15:0] npc);
        vec_t v;
        v.instr = instr; v.psr = p; v.op = op; v.a1 = a1; v.a2 = a2;
        v.wr = w; v.flags = f; v.pc = npc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] prev_pc;

        //        instr     psr       op    a1       a2       wr  flags     next pc
        tbl[0]  = mk(16'h0120, 5'b00000, 4'h0, 16'h0001, 16'h0002, 1, 5'b00000, 16'h0001);
        tbl[1]  = mk(16'h2110, 5'b10000, 4'h2, 16'h0001, 16'h0001, 0, 5'b10000, 16'h0002);
        tbl[2]  = mk(16'h8004, 5'b11111, 4'h2, 16'h0001, 16'h0001, 0, 5'b10000, 16'h0007);
        tbl[3]  = mk(16'h2110, 5'b00000, 4'h2, 16'h0001, 16'h0001, 0, 5'b00000, 16'h0008);
        tbl[4]  = mk(16'h90FE, 5'b11111, 4'h2, 16'h0001, 16'h0001, 0, 5'b00000, 16'h0007);
        tbl[5]  = mk(16'h8004, 5'b11111, 4'h2, 16'h0001, 16'h0001, 0, 5'b00000, 16'h0008);
        tbl[6]  = mk(16'hA0F0, 5'b11111, 4'h2, 16'h0001, 16'h0001, 0, 5'b00000, 16'hFFF9);
        tbl[7]  = mk(16'hA006, 5'b11111, 4'h2, 16'h0001, 16'h0001, 0, 5'b00000, 16'h0000);
        tbl[8]  = mk(16'h1345, 5'b01010, 4'h1, 16'h0003, 16'h0004, 1, 5'b01010, 16'h0001);
        tbl[9]  = mk(16'h73AB, 5'b00001, 4'h7, 16'h0003, 16'h00AB, 1, 5'b00001, 16'h0002);
        tbl[10] = mk(16'hB123, 5'b11111, 4'h7, 16'h0003, 16'h00AB, 0, 5'b00001, 16'h0003);
        tbl[11] = mk(16'h6FED, 5'b00100, 4'h6, 16'h000F, 16'h000E, 1, 5'b00100, 16'h0004);
        tbl[12] = mk(16'h9003, 5'b11111, 4'h6, 16'h000F, 16'h000E, 0, 5'b00100, 16'h0008);
        tbl[13] = mk(16'h4000, 5'b10000, 4'h4, 16'h0000, 16'h0000, 1, 5'b10000, 16'h0009);
        tbl[14] = mk(16'h9003, 5'b00000, 4'h4, 16'h0000, 16'h0000, 0, 5'b10000, 16'h000A);
        tbl[15] = mk(16'h80FF, 5'b00000, 4'h4, 16'h0000, 16'h0000, 0, 5'b10000, 16'h000A);

        reset_n    = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 16'h0120;
        psr        = 5'b11111;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_wr", wr, 0);
        chk("rst_flags", flags, 0);
        chk("rst_halted", halted, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_addr1", addr1, 0);
        chk("rst_addr2", addr2, 0);

        reset_n = 1'b1;
        prev_pc = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            imem_rdata = tbl[i].instr;
            psr        = tbl[i].psr;
            imem_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_req", i), imem_req, 1);
            chk($sformatf("v%0d_addr", i), imem_addr, prev_pc);
            @(negedge clk);
            imem_rdata = 16'hFFFF;
            chk($sformatf("v%0d_dec_wr", i), wr, 0);
            chk($sformatf("v%0d_dec_req", i), imem_req, 0);
            @(negedge clk);
            chk($sformatf("v%0d_opcode", i), opcode, tbl[i].op);
            chk($sformatf("v%0d_addr1", i), addr1, tbl[i].a1);
            chk($sformatf("v%0d_addr2", i), addr2, tbl[i].a2);
            chk($sformatf("v%0d_wr", i), wr, tbl[i].wr);
            @(negedge clk);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("v%0d_flags", i), flags, tbl[i].flags);
            chk($sformatf("v%0d_fetch_wr", i), wr, 0);
            prev_pc = tbl[i].pc;
        end

        // LUI with three memory stall cycles: request held four cycles on a constant address.
        imem_rdata = 16'h73AB;
        psr        = 5'b00000;
        imem_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) imem_valid = 1'b1;
            #1;
            chk($sformatf("stall%0d_req", k), imem_req, 1);
            chk($sformatf("stall%0d_addr", k), imem_addr, 16'h000A);
            @(negedge clk);
        end
        chk("stall_dec_req", imem_req, 0);
        @(negedge clk);
        chk("stall_wr", wr, 1);
        chk("stall_addr1", addr1, 16'h0003);
        chk("stall_addr2", addr2, 16'h00AB);
        @(negedge clk);
        chk("stall_pc", pc, 16'h000B);
        chk("stall_flags", flags, 5'b00000);
        chk("stall_req_back", imem_req, 1);

        // HALT: frozen for 20 cycles, flags untouched, exit only through reset.
        imem_rdata = 16'hF000;
        psr        = 5'b11111;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            chk("halt_halted", halted, 1);
            chk("halt_req", imem_req, 0);
            chk("halt_wr", wr, 0);
            chk("halt_pc", pc, 16'h000B);
            @(negedge clk);
        end
        chk("halt_flags", flags, 5'b00000);
        reset_n = 1'b0;
        #1;
        chk("halt_rst_pc", pc, 16'h0000);
        chk("halt_rst_halted", halted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        imem_rdata = 16'h0120;
        #1;
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 16'h0000);

        // Reset asserted mid-EXECUTE of ADD aborts the write and the pc/flags update.
        @(negedge clk);
        @(negedge clk);
        chk("abort_wr_before", wr, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_wr_async", wr, 0);
        chk("abort_req", imem_req, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pc", pc, 16'h0000);
        chk("abort_flags", flags, 5'b00000);
        chk("abort_opcode", opcode, 4'h0);
        reset_n = 1'b1;
        psr     = 5'b01000;
        #1;
        chk("abort_resume_req", imem_req, 1);
        repeat (3) @(negedge clk);
        chk("post_pc", pc, 16'h0001);
        chk("post_flags", flags, 5'b01000);
        chk("post_addr2", addr2, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
